// File: rtl/harmonic_decay_seq_if.sv
// Bus between the harmonic loop controller and the decay sequencer:
// series control and per-channel payload in, issued harmonic out.
interface harmonic_decay_seq_if #(
    parameter int unsigned DIV_BIT  = 8,
    parameter int unsigned HARM_BIT = 7,
    parameter int unsigned CHANNELS = 2
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                         i_Restart;
    logic                         i_Start;
    logic [1:0]                   i_Mode;
    logic [CHANNELS*DIV_BIT-1:0]  i_Scale;
    logic [CHANNELS*DIV_BIT-1:0]  i_Initial;
    logic [HARM_BIT-1:0]          i_Max_Harm;
    logic [DIV_BIT-1:0]           o_Mult;
    logic [HARM_BIT-1:0]          o_Harm;
    logic [CH_W-1:0]              o_Channel;
    logic                         o_Valid;
    logic                         o_Ready;
    logic                         o_Done;

    modport master (
        output i_Restart, i_Start, i_Mode, i_Scale, i_Initial, i_Max_Harm,
        input  o_Mult, o_Harm, o_Channel, o_Valid, o_Ready, o_Done
    );

    modport slave (
        input  i_Restart, i_Start, i_Mode, i_Scale, i_Initial, i_Max_Harm,
        output o_Mult, o_Harm, o_Channel, o_Valid, o_Ready, o_Done
    );
endinterface

// File: rtl/harmonic_decay_seq.sv
// Multi-channel harmonic amplitude sequencer: issues one multiple per harmonic
// and decays the owning channel linearly, exponentially (serial multiply) or not at all.
module harmonic_decay_seq #(
    parameter int unsigned DIV_BIT  = 8,
    parameter int unsigned HARM_BIT = 7,
    parameter int unsigned CHANNELS = 2
) (
    input logic                  i_Clock,
    input logic                  i_Reset_n,
    harmonic_decay_seq_if.slave  bus
);
    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CH_N  = 2 ** CH_W;
    localparam int unsigned ACC_W = 2 * DIV_BIT + 1;
    localparam int unsigned CNT_W = $clog2(DIV_BIT + 1);

    typedef enum logic [1:0] {S_WAIT, S_RUN, S_MUL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [HARM_BIT-1:0] harm_q, harm_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [HARM_BIT-1:0] max_q, max_d;
    logic [1:0]          mode_q, mode_d;
    logic [DIV_BIT-1:0]  mult_q [CH_N];
    logic [DIV_BIT-1:0]  mult_d [CH_N];

    logic [CH_W-1:0]     mul_ch_q, mul_ch_d;
    logic [DIV_BIT-1:0]  mpl_q, mpl_d;
    logic [ACC_W-1:0]    fac_q, fac_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DIV_BIT-1:0]  mult_o_q, mult_o_d;
    logic [HARM_BIT-1:0] harm_o_q, harm_o_d;
    logic [CH_W-1:0]     chan_o_q, chan_o_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;

    logic [DIV_BIT-1:0]  cur_mult;
    logic [DIV_BIT-1:0]  cur_scale;
    logic [DIV_BIT:0]    factor;
    logic [ACC_W-1:0]    acc_sum;

    assign cur_mult  = mult_q[chan_q];
    assign cur_scale = bus.i_Scale[chan_q*DIV_BIT +: DIV_BIT];
    assign factor    = {1'b1, {DIV_BIT{1'b0}}} - {1'b0, cur_scale};
    // One shift-add step: multiplier consumed LSB-first, multiplicand shifted up
    assign acc_sum   = acc_q + (mpl_q[0] ? fac_q : ACC_W'(0));

    assign bus.o_Mult    = mult_o_q;
    assign bus.o_Harm    = harm_o_q;
    assign bus.o_Channel = chan_o_q;
    assign bus.o_Valid   = valid_q;
    assign bus.o_Ready   = ready_q;
    assign bus.o_Done    = done_q;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q  <= S_WAIT;
            harm_q   <= '0;
            chan_q   <= '0;
            max_q    <= '0;
            mode_q   <= '0;
            for (int c = 0; c < CH_N; c++) mult_q[c] <= '0;
            mul_ch_q <= '0;
            mpl_q    <= '0;
            fac_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mult_o_q <= '0;
            harm_o_q <= '0;
            chan_o_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            harm_q   <= harm_d;
            chan_q   <= chan_d;
            max_q    <= max_d;
            mode_q   <= mode_d;
            mult_q   <= mult_d;
            mul_ch_q <= mul_ch_d;
            mpl_q    <= mpl_d;
            fac_q    <= fac_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mult_o_q <= mult_o_d;
            harm_o_q <= harm_o_d;
            chan_o_q <= chan_o_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        harm_d   = harm_q;
        chan_d   = chan_q;
        max_d    = max_q;
        mode_d   = mode_q;
        mult_d   = mult_q;
        mul_ch_d = mul_ch_q;
        mpl_d    = mpl_q;
        fac_d    = fac_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mult_o_d = mult_o_q;
        harm_o_d = harm_o_q;
        chan_o_d = chan_o_q;
        valid_d  = 1'b0;
        done_d   = done_q;

        // Restart beats Start and aborts any multiply in flight
        if (bus.i_Restart) begin
            for (int c = 0; c < CHANNELS; c++) mult_d[c] = bus.i_Initial[c*DIV_BIT +: DIV_BIT];
            mode_d  = bus.i_Mode;
            max_d   = bus.i_Max_Harm;
            harm_d  = '0;
            chan_d  = '0;
            done_d  = 1'b0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bus.i_Start) begin
                        mult_o_d = cur_mult;
                        harm_o_d = harm_q;
                        chan_o_d = chan_q;
                        valid_d  = 1'b1;
                        if (harm_q == max_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            harm_d = harm_q + HARM_BIT'(1);
                            chan_d = (chan_q == CH_W'(CHANNELS - 1)) ? '0 : chan_q + CH_W'(1);
                            case (mode_q)
                                2'd1: begin
                                    state_d  = S_MUL;
                                    mul_ch_d = chan_q;
                                    mpl_d    = cur_mult;
                                    fac_d    = ACC_W'(factor);
                                    acc_d    = '0;
                                    cnt_d    = '0;
                                end
                                2'd2: ;
                                default: mult_d[chan_q] = (cur_mult >= cur_scale) ?
                                                          cur_mult - cur_scale : '0;
                            endcase
                        end
                    end
                end
                S_MUL: begin
                    acc_d = acc_sum;
                    mpl_d = mpl_q >> 1;
                    fac_d = fac_q << 1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_BIT - 1)) begin
                        mult_d[mul_ch_q] = acc_sum[2*DIV_BIT-1:DIV_BIT];
                        state_d = S_RUN;
                    end
                end
                default: ;
            endcase
        end

        ready_d = (state_d == S_RUN);
    end
endmodule

// File: tb/tb_harmonic_decay_seq.sv
// Directed bench for harmonic_decay_seq: a two-channel and a one-channel instance.
module tb_harmonic_decay_seq;
    logic clk = 1'b0;
    logic rst_n1, rst_n2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    harmonic_decay_seq_if #(.DIV_BIT(8), .HARM_BIT(7), .CHANNELS(2)) b2 ();
    harmonic_decay_seq_if #(.DIV_BIT(8), .HARM_BIT(7), .CHANNELS(1)) b1 ();

    harmonic_decay_seq #(.DIV_BIT(8), .HARM_BIT(7), .CHANNELS(2)) dut2 (
        .i_Clock(clk), .i_Reset_n(rst_n2), .bus(b2.slave));
    harmonic_decay_seq #(.DIV_BIT(8), .HARM_BIT(7), .CHANNELS(1)) dut1 (
        .i_Clock(clk), .i_Reset_n(rst_n1), .bus(b1.slave));

    typedef struct packed {
        int          sel;
        logic [1:0]  md;
        logic [15:0] ini;
        logic [15:0] sc;
        logic [6:0]  mx;
        int          n;
        logic [47:0] em;
        logic [5:0]  ec;
    } vec_t;

    vec_t vt [7];

    int qm[$], qh[$], qc[$], qd[$], qs[$];

    // Strobe capture from both instances
    always @(negedge clk) begin
        if (b2.o_Valid) begin
            qm.push_back(int'(b2.o_Mult)); qh.push_back(int'(b2.o_Harm));
            qc.push_back(int'(b2.o_Channel)); qd.push_back(int'(b2.o_Done)); qs.push_back(2);
        end
        if (b1.o_Valid) begin
            qm.push_back(int'(b1.o_Mult)); qh.push_back(int'(b1.o_Harm));
            qc.push_back(int'(b1.o_Channel)); qd.push_back(int'(b1.o_Done)); qs.push_back(1);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic qclear();
        qm.delete(); qh.delete(); qc.delete(); qd.delete(); qs.delete();
    endtask

    task automatic drive(input int sel, input logic rs, input logic st, input logic [1:0] md,
                         input logic [15:0] ini, input logic [15:0] sc, input logic [6:0] mx);
        if (sel == 1) begin
            b1.i_Restart = rs; b1.i_Start = st; b1.i_Mode = md;
            b1.i_Initial = ini[7:0]; b1.i_Scale = sc[7:0]; b1.i_Max_Harm = mx;
        end else begin
            b2.i_Restart = rs; b2.i_Start = st; b2.i_Mode = md;
            b2.i_Initial = ini; b2.i_Scale = sc; b2.i_Max_Harm = mx;
        end
    endtask

    task automatic chk_reset(input int sel);
        if (sel == 1) begin
            chk("rst1_valid", int'(b1.o_Valid), 0); chk("rst1_mult", int'(b1.o_Mult), 0);
            chk("rst1_harm", int'(b1.o_Harm), 0);   chk("rst1_ready", int'(b1.o_Ready), 0);
            chk("rst1_done", int'(b1.o_Done), 0);   chk("rst1_chan", int'(b1.o_Channel), 0);
        end else begin
            chk("rst2_valid", int'(b2.o_Valid), 0); chk("rst2_mult", int'(b2.o_Mult), 0);
            chk("rst2_harm", int'(b2.o_Harm), 0);   chk("rst2_ready", int'(b2.o_Ready), 0);
            chk("rst2_done", int'(b2.o_Done), 0);   chk("rst2_chan", int'(b2.o_Channel), 0);
        end
    endtask

    initial begin
        int w;
        int n;
        vt[0] = '{sel:2, md:2'd0, ini:{8'd100, 8'd200}, sc:{8'd30, 8'd50}, mx:7'd5, n:6,
                  em:{8'd40, 8'd100, 8'd70, 8'd150, 8'd100, 8'd200}, ec:6'b101010};
        vt[1] = '{sel:1, md:2'd0, ini:16'd20, sc:16'd50, mx:7'd3, n:4,
                  em:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20}, ec:6'b000000};
        vt[2] = '{sel:1, md:2'd1, ini:16'd255, sc:16'd128, mx:7'd2, n:3,
                  em:{8'd0, 8'd0, 8'd0, 8'd63, 8'd127, 8'd255}, ec:6'b000000};
        vt[3] = '{sel:1, md:2'd1, ini:16'd255, sc:16'd0, mx:7'd2, n:3,
                  em:{8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255}, ec:6'b000000};
        vt[4] = '{sel:1, md:2'd2, ini:16'd77, sc:16'd9, mx:7'd3, n:4,
                  em:{8'd0, 8'd0, 8'd77, 8'd77, 8'd77, 8'd77}, ec:6'b000000};
        vt[5] = '{sel:2, md:2'd3, ini:{8'd5, 8'd10}, sc:{8'd1, 8'd3}, mx:7'd0, n:1,
                  em:{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10}, ec:6'b000000};
        vt[6] = '{sel:2, md:2'd2, ini:{8'd33, 8'd77}, sc:{8'd4, 8'd4}, mx:7'd3, n:4,
                  em:{8'd0, 8'd0, 8'd33, 8'd77, 8'd33, 8'd77}, ec:6'b001010};

        rst_n1 = 1'b0; rst_n2 = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk_reset(1);
        chk_reset(2);
        rst_n1 = 1'b1; rst_n2 = 1'b1;

        // Start before any Restart is ignored
        qclear();
        drive(2, 0, 1, 0, 16'hFFFF, 0, 7'd5);
        repeat (4) tick();
        drive(2, 0, 0, 0, 0, 0, 0);
        tick();
        chk("wait_no_valid", qm.size(), 0);

        for (int v = 0; v < 7; v++) begin
            qclear();
            drive(vt[v].sel, 1, 0, vt[v].md, vt[v].ini, vt[v].sc, vt[v].mx);
            tick();
            drive(vt[v].sel, 0, 1, vt[v].md, vt[v].ini, vt[v].sc, vt[v].mx);
            repeat (40) tick();
            drive(vt[v].sel, 0, 0, vt[v].md, vt[v].ini, vt[v].sc, vt[v].mx);
            repeat (2) tick();
            chk($sformatf("v%0d_count", v), qm.size(), vt[v].n);
            for (int i = 0; i < vt[v].n && i < qm.size(); i++) begin
                chk($sformatf("v%0d_mult%0d", v, i), qm[i], int'(vt[v].em[i*8 +: 8]));
                chk($sformatf("v%0d_harm%0d", v, i), qh[i], i);
                chk($sformatf("v%0d_chan%0d", v, i), qc[i], int'(vt[v].ec[i]));
                chk($sformatf("v%0d_done%0d", v, i), qd[i], (i == vt[v].n - 1) ? 1 : 0);
                chk($sformatf("v%0d_src%0d", v, i), qs[i], vt[v].sel);
            end
            if (vt[v].sel == 1) begin
                chk($sformatf("v%0d_done_hold", v), int'(b1.o_Done), 1);
                chk($sformatf("v%0d_ready_end", v), int'(b1.o_Ready), 0);
            end else begin
                chk($sformatf("v%0d_done_hold", v), int'(b2.o_Done), 1);
                chk($sformatf("v%0d_ready_end", v), int'(b2.o_Ready), 0);
            end
        end

        // Exponential: o_Ready low for exactly DIV_BIT cycles after each non-final strobe
        qclear();
        drive(1, 1, 0, 1, 16'd255, 16'd128, 7'd2);
        tick();
        drive(1, 0, 1, 1, 16'd255, 16'd128, 7'd2);
        w = 0;
        while (!b1.o_Valid && w < 50) begin @(negedge clk); w++; end
        chk("exp_first_strobe", (w < 50) ? 1 : 0, 1);
        for (int g = 0; g < 2; g++) begin
            n = 0;
            while (!b1.o_Ready && n < 20) begin n++; @(negedge clk); end
            chk($sformatf("exp_gap%0d", g), n, 8);
            chk($sformatf("exp_gap_strobes%0d", g), qm.size(), g + 1);
            @(negedge clk);
            chk($sformatf("exp_valid%0d", g), int'(b1.o_Valid), 1);
            chk($sformatf("exp_mult%0d", g), int'(b1.o_Mult), (g == 0) ? 127 : 63);
        end
        chk("exp_final_done", int'(b1.o_Done), 1);
        chk("exp_final_ready", int'(b1.o_Ready), 0);
        tick();
        drive(1, 0, 0, 1, 16'd255, 16'd128, 7'd2);

        // Restart three cycles into a multiply: aborted result must never land
        drive(1, 1, 0, 1, 16'd255, 16'd128, 7'd2);
        tick();
        drive(1, 0, 1, 1, 16'd255, 16'd128, 7'd2);
        tick();
        drive(1, 0, 0, 1, 16'd255, 16'd128, 7'd2);
        repeat (3) tick();
        qclear();
        chk("abort_in_mul_ready", int'(b1.o_Ready), 0);
        drive(1, 1, 0, 1, 16'd200, 16'd128, 7'd2);
        tick();
        chk("abort_ready", int'(b1.o_Ready), 1);
        drive(1, 0, 1, 1, 16'd200, 16'd128, 7'd2);
        repeat (30) tick();
        drive(1, 0, 0, 1, 16'd200, 16'd128, 7'd2);
        chk("abort_count", qm.size(), 3);
        if (qm.size() >= 3) begin
            chk("abort_mult0", qm[0], 200); chk("abort_harm0", qh[0], 0);
            chk("abort_mult1", qm[1], 100); chk("abort_mult2", qm[2], 50);
        end

        // Restart and Start together: Start dropped
        qclear();
        drive(1, 1, 1, 1, 16'd255, 16'd128, 7'd2);
        tick();
        drive(1, 0, 0, 1, 16'd255, 16'd128, 7'd2);
        @(negedge clk);
        chk("coll_valid", int'(b1.o_Valid), 0);
        chk("coll_ready", int'(b1.o_Ready), 1);
        chk("coll_done", int'(b1.o_Done), 0);
        tick();
        chk("coll_count", qm.size(), 0);

        // Reset mid-series overrides a simultaneous Restart
        drive(2, 1, 0, 0, {8'd100, 8'd200}, {8'd30, 8'd50}, 7'd5);
        tick();
        drive(2, 0, 1, 0, {8'd100, 8'd200}, {8'd30, 8'd50}, 7'd5);
        repeat (3) tick();
        rst_n2 = 1'b0;
        drive(2, 1, 1, 0, {8'd100, 8'd200}, {8'd30, 8'd50}, 7'd5);
        tick();
        chk_reset(2);
        rst_n2 = 1'b1;
        drive(2, 0, 1, 0, {8'd100, 8'd200}, {8'd30, 8'd50}, 7'd5);
        qclear();
        repeat (10) tick();
        drive(2, 0, 0, 0, 0, 0, 0);
        chk("post_rst_count", qm.size(), 0);
        chk("post_rst_ready", int'(b2.o_Ready), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/harmonic_decay_seq.md
# harmonic_decay_seq

Multi-channel harmonic amplitude sequencer for the additive oscillator. Once per harmonic it issues a scaling multiple for harmonic h on channel h mod CHANNELS, then attenuates that channel's running multiple. Three decay modes are supported: linear saturating subtract, exponential (serial shift-add multiply), and hold. It sits between the per-sample harmonic loop controller and the harmonic level multiplier. It adds odd/even (or wider) channel splitting, an end-of-series flag and a ready handshake over the original single linear scaler.

## Interface
- DIV_BIT, 8, width of multiples, scales and initial values
- HARM_BIT, 7, width of harmonic index
- CHANNELS, 2, number of independent decay channels (≥1)
- i_Clock  in  1  system clock; all logic on rising edge
- i_Reset_n  in  1  synchronous, active-low reset
- i_Restart  in  1  begin new series: load initials, mode and max harmonic
- i_Start  in  1  request next harmonic; honoured only when o_Ready=1
- i_Mode  in  2  0 linear, 1 exponential, 2 hold, 3 treated as linear; sampled on i_Restart
- i_Scale  in  CHANNELS*DIV_BIT  per-channel attenuation, channel c at [c*DIV_BIT +: DIV_BIT]; sampled on each accepted i_Start
- i_Initial  in  CHANNELS*DIV_BIT  per-channel start multiple, same packing; sampled on i_Restart
- i_Max_Harm  in  HARM_BIT  index of last harmonic in series; sampled on i_Restart
- o_Mult  out  DIV_BIT  multiple for issued harmonic
- o_Harm  out  HARM_BIT  index of issued harmonic
- o_Channel  out  clog2(CHANNELS) (min 1)  channel of issued harmonic
- o_Valid  out  1  one-cycle strobe: o_Mult/o_Harm/o_Channel valid
- o_Ready  out  1  block will accept i_Start this cycle
- o_Done  out  1  series complete; held until i_Restart or reset

## Operation
- States: WAIT (after reset, no series loaded), RUN, MUL (exponential multiply in progress), DONE.
- Reset (i_Reset_n=0): every output and every channel multiple is 0. State is WAIT and o_Ready=0. i_Start is ignored until i_Restart.
- Restart, in any state including mid-MUL:
  - Loads all channel multiples from i_Initial and latches i_Mode and i_Max_Harm.
  - Clears the harmonic counter and o_Done.
  - Enters RUN.
  - Any multiply in progress is aborted and discarded.
- Restart and Start asserted in the same cycle: Restart wins and Start is dropped.
- Accepted Start (RUN, o_Ready=1), current harmonic h, channel c = h mod CHANNELS:
  - Registers o_Mult=mult[c], o_Harm=h, o_Channel=c and o_Valid=1.
  - Latches scale[c].
  - If h == max harmonic: enters DONE, o_Done=1; no decay is applied.
  - Otherwise h increments and the channel decays per mode:
    - Linear: mult[c] <= (mult[c] ≥ scale) ? mult[c]−scale : 0, written on the same edge; stays in RUN.
    - Exponential: enters MUL. mult[c] <= floor(mult[c]·(2^DIV_BIT − scale) / 2^DIV_BIT). Computed LSB-first by shift-add over DIV_BIT cycles. Factor is DIV_BIT+1 bits, accumulator 2·DIV_BIT+1 bits. Result ≤ original value; scale=0 leaves the value unchanged.
    - Hold: no change.
- i_Start while o_Ready=0 (WAIT, MUL, DONE): ignored and not queued.
- Harmonic counter never wraps: DONE is reached at i_Max_Harm ≤ 2^HARM_BIT−1. i_Max_Harm=0 issues exactly one harmonic.
- Channels not selected by h are untouched.

## Timing
- Start sampled high at edge k → outputs and o_Valid=1 during cycle k+1; o_Valid is low the cycle after unless another Start was accepted.
- Linear/hold: o_Ready stays 1, so i_Start held high gives one harmonic per cycle.
- Exponential: o_Ready=0 in cycles k+1..k+DIV_BIT; updated mult[c] is written at edge k+DIV_BIT; o_Ready=1 from cycle k+DIV_BIT+1. Throughput is one harmonic per DIV_BIT+1 cycles.
- Restart at edge k → o_Ready=1 and o_Done=0 from cycle k+1; the first Start can be accepted at edge k+1.
- o_Done rises in the same cycle as the final o_Valid; o_Ready=0 from that cycle.
- Reset at any edge overrides everything, including Restart.

## Test plan
- Linear, CHANNELS=2, DIV_BIT=8: Initial ch0=200, ch1=100; Scale ch0=50, ch1=30; Max_Harm=5; Restart then i_Start held high.
  - Six consecutive o_Valid cycles: o_Mult 200,100,150,70,100,40; o_Channel 0,1,0,1,0,1; o_Harm 0..5.
  - o_Done high with the 6th strobe; further Starts produce no o_Valid.
- Linear saturation, CHANNELS=1: Initial=20, Scale=50, Max_Harm=3 → o_Mult 20,0,0,0.
- Exponential, CHANNELS=1: Initial=255, Scale=128, Max_Harm=2, i_Start held.
  - o_Mult 255,127,63.
  - o_Ready low exactly 8 cycles after each non-final strobe; Starts during the gap are ignored.
  - A separate run with Scale=0 gives 255,255,255.
- Hold mode: Initial=77 → every strobe o_Mult=77 until Done.
- Collisions, in exponential mode:
  - Restart 3 cycles into MUL → no write-back; next strobe shows the reloaded initial value with o_Harm=0.
  - Restart+Start in the same cycle → no o_Valid that cycle+1; o_Ready=1.
- Reset mid-series → next cycle all outputs 0, o_Ready=0; Start without Restart yields no o_Valid.
